// File: rtl/preload_pkg.sv
//------------------------------------------------------------------------------
// preload_pkg : shared constants and state encoding for the pre-load sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package preload_pkg;

    localparam int DEPTH      = 64;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int W_W        = 8;
    localparam int A_W        = 7;
    localparam int CW_CYCLES  = 8;
    localparam int CAL_CYCLES = 24;

    // One phase counter serves both windows, so it is sized for the longer one.
    localparam int PH_W = $clog2((CAL_CYCLES > CW_CYCLES) ? CAL_CYCLES : CW_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_LDONE = 3'd3,
        S_PRECW = 3'd4,
        S_CAL   = 3'd5,
        S_FIN   = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/preload_phase_cnt.sv
//------------------------------------------------------------------------------
// preload_phase_cnt : loadable down-counter with zero flag for phase windows
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module preload_phase_cnt #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/preload_sequencer.sv
//------------------------------------------------------------------------------
// preload_sequencer : feeds 64 weight/activation beats to memory, then runs the
// load-done / CWeight / Cal phases. Optional macro: PRELOAD_STALL_CNT_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module preload_sequencer
    import preload_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_W-1:0]    in_weight,
    input  logic [A_W-1:0]    in_act,
    output logic [W_W-1:0]    Weight,
    output logic [ADDR_W-1:0] Weight_Mem_Address_in,
    output logic [A_W-1:0]    Activation,
    output logic [ADDR_W-1:0] Activation_Mem_Address_in,
    output logic              mem_wr,
    output logic              load_mem_done,
    output logic              PreLoad_CWeight,
    output logic              Cal,
    output logic              busy,
`ifdef PRELOAD_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [W_W-1:0]    weight_q, weight_d;
    logic [A_W-1:0]    act_q, act_d;
    logic              mem_wr_q, mem_wr_d;

    logic              ph_load;
    logic [PH_W-1:0]   ph_val;
    logic              ph_en;
    logic              ph_zero;

    preload_phase_cnt #(
        .WIDTH (PH_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .en_i       (ph_en),
        .zero_o     (ph_zero)
    );

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        addr_d          = addr_q;
        weight_d        = weight_q;
        act_d           = act_q;
        mem_wr_d        = 1'b0;
        ph_load         = 1'b0;
        ph_val          = '0;
        ph_en           = 1'b0;
        in_ready        = 1'b0;
        load_mem_done   = 1'b0;
        PreLoad_CWeight = 1'b0;
        Cal             = 1'b0;
        done            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    beat_d  = '0;
                end
            end
            S_LOAD: begin
                // Ready drops with abort so a handshake seen by the host is never discarded.
                in_ready = !abort;
                if (in_valid) begin
                    weight_d = in_weight;
                    act_d    = in_act;
                    addr_d   = beat_q;
                    mem_wr_d = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_FLUSH;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_LDONE;
            end
            S_LDONE: begin
                load_mem_done = 1'b1;
                ph_load       = 1'b1;
                ph_val        = PH_W'(CW_CYCLES - 1);
                state_d       = S_PRECW;
            end
            S_PRECW: begin
                PreLoad_CWeight = 1'b1;
                if (ph_zero) begin
                    ph_load = 1'b1;
                    ph_val  = PH_W'(CAL_CYCLES - 1);
                    state_d = S_CAL;
                end else begin
                    ph_en = 1'b1;
                end
            end
            S_CAL: begin
                Cal = 1'b1;
                if (ph_zero) begin
                    state_d = S_FIN;
                end else begin
                    ph_en = 1'b1;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition; captured data and address are kept.
        if (abort) begin
            state_d  = S_IDLE;
            beat_d   = '0;
            addr_d   = addr_q;
            weight_d = weight_q;
            act_d    = act_q;
            mem_wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            addr_q   <= '0;
            weight_q <= '0;
            act_q    <= '0;
            mem_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            weight_q <= weight_d;
            act_q    <= act_d;
            mem_wr_q <= mem_wr_d;
        end
    end

    assign Weight                    = weight_q;
    assign Activation                = act_q;
    assign Weight_Mem_Address_in     = addr_q;
    assign Activation_Mem_Address_in = addr_q;
    assign mem_wr                    = mem_wr_q;
    assign busy                      = (state_q != S_IDLE);

`ifdef PRELOAD_STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start && !abort) begin
            stall_d = '0;
        end else if ((state_q == S_LOAD) && !in_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire
